pulse_stretch: RTL

Multi-channel pulse stretcher, the inverse of the key one-shot: turns single-cycle event pulses back into fixed-length level signals long enough to see on an LED or sample in a slow domain. It sits between one-shot or event sources and the LED outputs on the board top level, e.g. to flash an LED for a fixed time on each key press. Each channel has its own countdown timer, an optional retrigger mode, an optional post-pulse holdoff, and a sticky overrun flag.

---
 rtl/pulse_stretch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pulse_stretch.sv
// Multi-channel pulse stretcher: each single-cycle event becomes a fixed-length
// level, with optional retrigger, post-pulse holdoff and a sticky overrun flag.

module pulse_stretch_ch #(
  parameter int STRETCH_CYCLES = 25000000,
  parameter int HOLDOFF_CYCLES = 0,
  parameter int RETRIGGER      = 1,
  parameter int CNT_W          = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse,
  input  logic clr,
  output logic level_q,
  output logic ovr_q,
  output logic busy_d
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  localparam logic [CNT_W-1:0] S_LD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] H_LD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_ovr, level_d, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_ovr = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d = ACTIVE;
          cnt_d   = S_LD;
        end
      end
      ACTIVE: begin
        // A retrigger on the last high cycle beats the exit, so no glitch.
        if (pulse && (RETRIGGER != 0)) begin
          cnt_d = S_LD;
        end else begin
          set_ovr = pulse;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLDOFF;
            cnt_d   = H_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        set_ovr = pulse;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ACTIVE);
    busy_d  = (state_d != IDLE);
    ovr_d   = set_ovr | (ovr_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

module pulse_stretch #(
  parameter int WIDTH          = 4,
  parameter int STRETCH_CYCLES = 25000000,
  parameter int HOLDOFF_CYCLES = 0,
  parameter int RETRIGGER      = 1,
  parameter int CNT_W          = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic [WIDTH-1:0] clr_overrun,
  output logic [WIDTH-1:0] level_out,
  output logic             busy,
  output logic [WIDTH-1:0] overrun
);
  logic [WIDTH-1:0] ch_busy_d;
  logic             busy_q, busy_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pulse_stretch_ch #(
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
      .RETRIGGER     (RETRIGGER),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .pulse  (pulse_in[g]),
      .clr    (clr_overrun[g]),
      .level_q(level_out[g]),
      .ovr_q  (overrun[g]),
      .busy_d (ch_busy_d[g])
    );
  end

  always_comb busy_d = |ch_busy_d;

  always_ff @(posedge clk) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule
